load_store_unit: RTL

MEM-stage initiator that drives the byte-addressed, word-ported data memory on behalf of the pipeline. It executes LB/LBU/LH/LHU/LW/SB/SH/SW. Sub-word stores are done as read-modify-write, because the memory only writes whole words. Loads are extracted and extended from the registered memory read word. Memory byte order is big-endian (byte offset 0 = bits[31:24]).

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a big-endian, word-ported data memory.
// Sub-word stores are read-modify-write; loads extract from the registered read word.
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        MEM_READ_EN,
  output logic        MEM_WRITE_EN,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_DATA_IN,
  input  logic [31:0] MEM_DATA_OUT
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP
  } state_t;

  state_t state, state_nxt;

  logic        wr_q, sgn_q, err_q;
  logic [1:0]  size_q, ofs_q;
  logic [31:0] wdata_q;

  logic [31:0] req_base;
  logic        req_err;
  logic        accept;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [31:0] merged;

  assign req_base = {REQ_ADDR[31:2], 2'b00};
  assign accept   = (state == IDLE) && REQ_VALID;

  always_comb begin
    req_err = 1'b0;
    unique case (1'b1)
      (REQ_SIZE == 2'b11):                   req_err = 1'b1;
      (REQ_SIZE == 2'b01 && REQ_ADDR[0]):    req_err = 1'b1;
      (REQ_SIZE == 2'b10 && |REQ_ADDR[1:0]): req_err = 1'b1;
      default:                               req_err = 1'b0;
    endcase
    if (req_base + 32'd3 >= MEM_SIZE)
      req_err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (REQ_VALID) begin
          if (req_err)
            state_nxt = RESP;
          else if (REQ_WRITE && REQ_SIZE == 2'b10)
            state_nxt = WR_ISSUE;
          else
            state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = wr_q ? WR_ISSUE : RESP;
      WR_ISSUE: state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Lane select: offset 0 is the most significant byte
  always_comb begin
    byte_v = 8'h00;
    unique case (ofs_q)
      2'd0: byte_v = MEM_DATA_OUT[31:24];
      2'd1: byte_v = MEM_DATA_OUT[23:16];
      2'd2: byte_v = MEM_DATA_OUT[15:8];
      2'd3: byte_v = MEM_DATA_OUT[7:0];
      default: byte_v = 8'h00;
    endcase
    half_v = ofs_q[1] ? MEM_DATA_OUT[15:0] : MEM_DATA_OUT[31:16];
    load_v = MEM_DATA_OUT;
    unique case (size_q)
      2'b00: load_v = {{24{sgn_q & byte_v[7]}}, byte_v};
      2'b01: load_v = {{16{sgn_q & half_v[15]}}, half_v};
      default: load_v = MEM_DATA_OUT;
    endcase
  end

  always_comb begin
    merged = MEM_DATA_OUT;
    if (size_q == 2'b01) begin
      if (ofs_q[1]) merged[15:0]  = wdata_q[15:0];
      else          merged[31:16] = wdata_q[15:0];
    end else begin
      unique case (ofs_q)
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = MEM_DATA_OUT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      sgn_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      ofs_q       <= 2'b00;
      wdata_q     <= '0;
      MEM_ADDRESS <= '0;
      MEM_DATA_IN <= '0;
      RSP_RDATA   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q        <= REQ_WRITE;
        sgn_q       <= REQ_SIGNED;
        err_q       <= req_err;
        size_q      <= REQ_SIZE;
        ofs_q       <= REQ_ADDR[1:0];
        wdata_q     <= REQ_WDATA;
        MEM_ADDRESS <= req_base;
        if (req_err)
          RSP_RDATA <= '0;
        if (REQ_WRITE && REQ_SIZE == 2'b10)
          MEM_DATA_IN <= REQ_WDATA;
      end
      if (state == RD_WAIT) begin
        if (wr_q) MEM_DATA_IN <= merged;
        else      RSP_RDATA   <= load_v;
      end
      if (state == WR_ISSUE)
        RSP_RDATA <= '0;
    end
  end

  assign REQ_READY    = (state == IDLE);
  assign MEM_READ_EN  = (state == RD_ISSUE);
  assign MEM_WRITE_EN = (state == WR_ISSUE);
  assign RSP_VALID    = (state == RESP);
  assign RSP_ERR      = (state == RESP) && err_q;

endmodule
